// File: rtl/window_min_max_tracker_pkg.sv
// Shared types and constants for the windowed min/max tracker.
// Holds the FSM encoding, the comparator result bundle and the register-update selector.
package window_min_max_tracker_pkg;

  localparam int DATA_W = 4;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_TRACK  = 2'd1,
    ST_REPORT = 2'd2
  } state_e;

  typedef struct packed {
    logic gt;
    logic lt;
    logic eq;
  } cmp_res_t;

  // Pick the candidate only on a strict win; equality and losses keep the stored value.
  function automatic logic [DATA_W-1:0] select_update(
    input cmp_res_t          res,
    input logic              want_gt,
    input logic [DATA_W-1:0] cand,
    input logic [DATA_W-1:0] cur
  );
    logic [DATA_W-1:0] pick;
    case ({res.gt, res.lt, res.eq})
      3'b100:  pick = want_gt ? cand : cur;
      3'b010:  pick = want_gt ? cur : cand;
      default: pick = cur;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/window_min_max_tracker_comparator.sv
// Four-bit magnitude comparator with cascade inputs.
// Cascade inputs only decide the outcome when the two operands are equal.
module four_bit_comparator
  import window_min_max_tracker_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              lt_in,
  input  logic              gt_in,
  input  logic              eq_in,
  output cmp_res_t          res
);

  // Magnitude compare, falling back to the cascade inputs on a tie.
  always_comb begin
    res = '{gt: 1'b0, lt: 1'b0, eq: 1'b0};
    if (a > b) begin
      res.gt = 1'b1;
    end else if (a < b) begin
      res.lt = 1'b1;
    end else begin
      res.gt = gt_in;
      res.lt = lt_in;
      res.eq = eq_in;
    end
  end

endmodule

// File: rtl/window_min_max_tracker.sv
// Tracks max/min of a 4-bit sample stream over fixed windows of WINDOW samples
// and hands each window result downstream with a valid/ready handshake.
module window_min_max_tracker
  import window_min_max_tracker_pkg::*;
#(
  parameter int WINDOW = 8,
  parameter int CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Clear,
  input  logic              InValid,
  output logic              InReady,
  input  logic [DATA_W-1:0] InData,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] OutMax,
  output logic [DATA_W-1:0] OutMin,
  output logic [CNT_W-1:0]  OutCount
);

  localparam logic [CNT_W-1:0] WINDOW_C = CNT_W'(WINDOW);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  state_e            state_r, state_n;
  logic [DATA_W-1:0] max_r, max_n, min_r, min_n;
  logic [CNT_W-1:0]  cnt_r, cnt_n;
  logic              out_valid_r, out_valid_n;
  logic [DATA_W-1:0] out_max_r, out_max_n, out_min_r, out_min_n;
  logic [CNT_W-1:0]  out_count_r, out_count_n;

  cmp_res_t          max_res_s, min_res_s;
  logic [DATA_W-1:0] max_upd_s, min_upd_s;
  logic [CNT_W-1:0]  cnt_upd_s;
  logic              accept_s, seed_s;

  four_bit_comparator cmp_max (
    .a     (InData),
    .b     (max_r),
    .lt_in (1'b0),
    .gt_in (1'b0),
    .eq_in (1'b1),
    .res   (max_res_s)
  );

  four_bit_comparator cmp_min (
    .a     (InData),
    .b     (min_r),
    .lt_in (1'b0),
    .gt_in (1'b0),
    .eq_in (1'b1),
    .res   (min_res_s)
  );

  assign InReady   = (state_r != ST_REPORT) | OutReady;
  assign accept_s  = InValid & InReady;
  assign max_upd_s = select_update(max_res_s, 1'b1, InData, max_r);
  assign min_upd_s = select_update(min_res_s, 1'b0, InData, min_r);
  assign cnt_upd_s = cnt_r + ONE_C;

  assign OutValid = out_valid_r;
  assign OutMax   = out_max_r;
  assign OutMin   = out_min_r;
  assign OutCount = out_count_r;

  // Next-state logic: Clear first, then the per-state window handling, then seeding.
  always_comb begin
    state_n     = state_r;
    max_n       = max_r;
    min_n       = min_r;
    cnt_n       = cnt_r;
    out_valid_n = out_valid_r;
    out_max_n   = out_max_r;
    out_min_n   = out_min_r;
    out_count_n = out_count_r;
    seed_s      = 1'b0;

    if (Clear) begin
      state_n     = ST_EMPTY;
      max_n       = 4'h0;
      min_n       = 4'hF;
      cnt_n       = '0;
      out_valid_n = 1'b0;
      seed_s      = accept_s;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          seed_s = accept_s;
        end
        ST_TRACK: begin
          if (accept_s) begin
            max_n = max_upd_s;
            min_n = min_upd_s;
            cnt_n = cnt_upd_s;
            if (cnt_upd_s == WINDOW_C) begin
              out_max_n   = max_upd_s;
              out_min_n   = min_upd_s;
              out_count_n = cnt_upd_s;
              out_valid_n = 1'b1;
              state_n     = ST_REPORT;
            end else begin
              state_n = ST_TRACK;
            end
          end else begin
            state_n = ST_TRACK;
          end
        end
        ST_REPORT: begin
          if (OutReady) begin
            out_valid_n = 1'b0;
            state_n     = ST_EMPTY;
            max_n       = 4'h0;
            min_n       = 4'hF;
            cnt_n       = '0;
            seed_s      = accept_s;
          end else begin
            state_n = ST_REPORT;
          end
        end
        default: begin
          state_n     = ST_EMPTY;
          max_n       = 4'h0;
          min_n       = 4'hF;
          cnt_n       = '0;
          out_valid_n = 1'b0;
        end
      endcase
    end

    // A seeding sample opens a window; with a one-sample window it is also the result.
    if (seed_s) begin
      max_n = InData;
      min_n = InData;
      cnt_n = ONE_C;
      if (WINDOW_C == ONE_C) begin
        out_max_n   = InData;
        out_min_n   = InData;
        out_count_n = ONE_C;
        out_valid_n = 1'b1;
        state_n     = ST_REPORT;
      end else begin
        state_n = ST_TRACK;
      end
    end else begin
      seed_s = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r     <= ST_EMPTY;
      max_r       <= 4'h0;
      min_r       <= 4'hF;
      cnt_r       <= '0;
      out_valid_r <= 1'b0;
      out_max_r   <= 4'h0;
      out_min_r   <= 4'h0;
      out_count_r <= '0;
    end else begin
      state_r     <= state_n;
      max_r       <= max_n;
      min_r       <= min_n;
      cnt_r       <= cnt_n;
      out_valid_r <= out_valid_n;
      out_max_r   <= out_max_n;
      out_min_r   <= out_min_n;
      out_count_r <= out_count_n;
    end
  end

endmodule

// File: tb/tb_window_min_max_tracker.sv
// Directed bench for window_min_max_tracker: an 8-sample instance and a 1-sample instance.
module tb_window_min_max_tracker;

  logic       clk;
  logic       rst_n;
  logic       clear, in_valid, out_ready;
  logic [3:0] in_data;
  logic       in_ready, out_valid;
  logic [3:0] out_max, out_min, out_count;

  logic       clear1, in_valid1, out_ready1;
  logic [3:0] in_data1;
  logic       in_ready1, out_valid1;
  logic [3:0] out_max1, out_min1;
  logic [0:0] out_count1;

  int n_cmp;
  int n_err;

  window_min_max_tracker #(.WINDOW(8)) dut (
    .Clk(clk), .Rst_n(rst_n), .Clear(clear),
    .InValid(in_valid), .InReady(in_ready), .InData(in_data),
    .OutValid(out_valid), .OutReady(out_ready),
    .OutMax(out_max), .OutMin(out_min), .OutCount(out_count)
  );

  window_min_max_tracker #(.WINDOW(1)) dut1 (
    .Clk(clk), .Rst_n(rst_n), .Clear(clear1),
    .InValid(in_valid1), .InReady(in_ready1), .InData(in_data1),
    .OutValid(out_valid1), .OutReady(out_ready1),
    .OutMax(out_max1), .OutMin(out_min1), .OutCount(out_count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string tag, input int mx, input int mn, input int cnt);
    check_eq({tag, "_valid"}, int'(out_valid), 1);
    check_eq({tag, "_max"},   int'(out_max),   mx);
    check_eq({tag, "_min"},   int'(out_min),   mn);
    check_eq({tag, "_count"}, int'(out_count), cnt);
  endtask

  int s1[8] = '{3, 9, 1, 9, 4, 0, 15, 7};
  int s4[7] = '{7, 8, 9, 7, 8, 9, 8};
  int s6[3] = '{0, 10, 15};

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 4'h0;
    clear1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0; in_data1 = 4'h0;
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Reset values
    check_eq("rst_valid", int'(out_valid), 0);
    check_eq("rst_max", int'(out_max), 0);
    check_eq("rst_min", int'(out_min), 0);
    check_eq("rst_count", int'(out_count), 0);
    check_eq("rst_in_ready", int'(in_ready), 1);
    check_eq("rst_valid1", int'(out_valid1), 0);

    // 1: mixed samples, downstream always ready
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 4'(s1[i]);
      tick();
      if (i == 6) check_eq("t1_no_early_valid", int'(out_valid), 0);
    end
    check_result("t1", 15, 0, 8);
    in_valid = 1'b0;
    tick();
    check_eq("t1_handshake_done", int'(out_valid), 0);

    // 2: all-equal samples, result held for test 3
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 4'h5;
      tick();
    end
    check_result("t2", 5, 5, 8);

    // 3: backpressure in REPORT, then release with a seeding sample
    in_valid = 1'b1; in_data = 4'h2;
    #1;
    check_eq("t3_in_ready_low", int'(in_ready), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_result("t3_hold", 5, 5, 8);
      check_eq("t3_hold_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    #1;
    check_eq("t3_in_ready_high", int'(in_ready), 1);
    tick();
    check_eq("t3_valid_drop", int'(out_valid), 0);
    for (int i = 0; i < 7; i++) begin
      in_data = 4'h5;
      tick();
    end
    check_result("t3_seeded", 5, 2, 8);
    in_valid = 1'b0;
    tick();

    // 4: Clear with a sample after four samples
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = 4'(i);
      tick();
    end
    clear = 1'b1; in_data = 4'h6;
    tick();
    clear = 1'b0;
    check_eq("t4_clear_no_valid", int'(out_valid), 0);
    for (int i = 0; i < 7; i++) begin
      in_data = 4'(s4[i]);
      tick();
      if (i == 5) check_eq("t4_no_early_valid", int'(out_valid), 0);
    end
    check_result("t4", 9, 6, 8);
    // Clear discards the pending report
    in_valid = 1'b0; out_ready = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    check_eq("t4_discard_valid", int'(out_valid), 0);
    check_eq("t4_discard_in_ready", int'(in_ready), 1);

    // 5: asynchronous reset at Cnt=5
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 4'(14 - i);
      tick();
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t5_async_valid", int'(out_valid), 0);
    check_eq("t5_async_max", int'(out_max), 0);
    check_eq("t5_async_min", int'(out_min), 0);
    check_eq("t5_async_count", int'(out_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 4'(i);
      tick();
      if (i == 7) check_eq("t5_no_early_valid", int'(out_valid), 0);
    end
    check_result("t5", 8, 1, 8);
    in_valid = 1'b0;
    tick();
    check_eq("t5_handshake_done", int'(out_valid), 0);

    // 6: one-sample windows, back to back
    in_valid1 = 1'b1; out_ready1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data1 = 4'(s6[i]);
      tick();
      check_eq("t6_valid", int'(out_valid1), 1);
      check_eq("t6_max", int'(out_max1), s6[i]);
      check_eq("t6_min", int'(out_min1), s6[i]);
      check_eq("t6_count", int'(out_count1), 1);
    end
    in_valid1 = 1'b0;
    tick();
    check_eq("t6_idle", int'(out_valid1), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
